// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the sequential subtractor state encoding.
package alu_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/borrow_bypass_slice.sv
// One 4-bit subtract slice: ripple borrow chain with a bypass mux when all bit pairs match.
module borrow_bypass_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bi,
    output logic [SLICE_W-1:0] d,
    output logic               bo,
    output logic               p
);

    logic [SLICE_W:0] bw;

    // Per-bit ripple difference and borrow, plus slice propagate.
    always_comb begin
        bw    = '0;
        d     = '0;
        bw[0] = bi;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            d[i]    = a[i] ^ b[i] ^ bw[i];
            bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
        p  = &(~(a ^ b));
        bo = p ? bi : bw[SLICE_W];
    end

endmodule

// File: rtl/borrow_bypass_subtractor_seq.sv
// Multi-cycle borrow-bypass subtractor: one 4-bit slice per clock, LSB slice first,
// valid/ready on both sides.
module borrow_bypass_subtractor_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
    input  logic                                  b_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      diff,
    output logic                                  b_out,
    output logic [$clog2(WIDTH/SLICE_W+1)-1:0]    skip_cnt
);

    localparam int unsigned NBLK  = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int unsigned CNT_W = $clog2(NBLK + 1);

    state_t             state;
    state_t             state_next;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               accept_c;
    logic               last_c;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               borrow_q;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] sa_c;
    logic [SLICE_W-1:0] sb_c;
    logic [SLICE_W-1:0] sd_c;
    logic               sbo_c;
    logic               sp_c;
    logic [WIDTH-1:0]   slice_mask_c;
    logic [WIDTH-1:0]   slice_val_c;

    assign accept_c = in_valid & in_ready;
    assign last_c   = (idx == IDX_W'(NBLK - 1));

    // State register with registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c)             state_next = RUN;
            RUN:     if (last_c)               state_next = DONE;
            DONE:    if (out_valid & out_ready) state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Handshake flags follow the state being entered.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_next)
            IDLE:    in_ready_d  = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Select the current slice of the latched operands and place its difference.
    always_comb begin
        sa_c         = SLICE_W'(a_q >> (32'(idx) * SLICE_W));
        sb_c         = SLICE_W'(b_q >> (32'(idx) * SLICE_W));
        slice_mask_c = WIDTH'({SLICE_W{1'b1}}) << (32'(idx) * SLICE_W);
        slice_val_c  = WIDTH'(sd_c) << (32'(idx) * SLICE_W);
    end

    borrow_bypass_slice u_slice (
        .a  (sa_c),
        .b  (sb_c),
        .bi (borrow_q),
        .d  (sd_c),
        .bo (sbo_c),
        .p  (sp_c)
    );

    // Operand capture, slice-by-slice result build and bypass counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx      <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            skip_cnt <= '0;
        end else if (state == IDLE) begin
            if (accept_c) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= b_in;
                idx      <= '0;
                diff     <= '0;
                b_out    <= 1'b0;
                skip_cnt <= '0;
            end
        end else if (state == RUN) begin
            diff     <= (diff & ~slice_mask_c) | slice_val_c;
            borrow_q <= sbo_c;
            skip_cnt <= skip_cnt + CNT_W'(sp_c);
            if (last_c) begin
                b_out <= sbo_c;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_borrow_bypass_subtractor_seq.sv
// Self-checking bench for the sequential borrow-bypass subtractor (WIDTH=16).
module tb_borrow_bypass_subtractor_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NBLK  = WIDTH / 4;
    localparam int unsigned CNT_W = $clog2(NBLK + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             b_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic [CNT_W-1:0] skip_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    borrow_bypass_subtractor_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .skip_cnt  (skip_cnt)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] d;
        logic             bo;
        logic [CNT_W-1:0] sk;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic, borrow from a widened compare, nibble-equality count.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] md, output logic mbo, output logic [CNT_W-1:0] msk);
        int unsigned ua, ub, n;
        ua  = 32'(ma);
        ub  = 32'(mb) + 32'(mbin);
        md  = WIDTH'(ua - ub);
        mbo = (ua < ub);
        n   = 0;
        for (int i = 0; i < int'(NBLK); i++)
            if (((ua >> (4 * i)) & 32'hF) == ((32'(mb) >> (4 * i)) & 32'hF)) n++;
        msk = CNT_W'(n);
    endtask

    // Issue one operation, check latency, optionally stall in DONE, then drain it.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin,
                          input int stall,
                          output logic [WIDTH-1:0] rd, output logic rbo, output logic [CNT_W-1:0] rsk);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(n < 50), 32'd1);
        a = ta; b = tb; b_in = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom);
            a = WIDTH'($urandom); b = WIDTH'($urandom); b_in = 1'($urandom);
            chk("in_ready_run", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(NBLK));
        rd = diff; rbo = b_out; rsk = skip_cnt;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            a = WIDTH'($urandom); b = WIDTH'($urandom); b_in = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_diff", 32'(diff), 32'(rd));
            chk("hold_bout", 32'(b_out), 32'(rbo));
            chk("hold_skip", 32'(skip_cnt), 32'(rsk));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t             vecs[4];
    logic [WIDTH-1:0] rd, md, ra, rb;
    logic             rbo, mbo, rbin;
    logic [CNT_W-1:0] rsk, msk;
    int               n;

    initial begin
        vecs[0] = '{a:16'h1234, b:16'h0234, bin:1'b0, d:16'h1000, bo:1'b0, sk:3'd3};
        vecs[1] = '{a:16'h0000, b:16'h0001, bin:1'b0, d:16'hFFFF, bo:1'b1, sk:3'd3};
        vecs[2] = '{a:16'hABCD, b:16'hABCD, bin:1'b1, d:16'hFFFF, bo:1'b1, sk:3'd4};
        vecs[3] = '{a:16'h8000, b:16'h0001, bin:1'b0, d:16'h7FFF, bo:1'b0, sk:3'd2};

        // Reset asserted mid-cycle takes effect immediately.
        #12 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(b_out), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, rd, rbo, rsk);
            chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(rbo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_skip", i), 32'(rsk), 32'(vecs[i].sk));
        end

        // Stall three cycles in DONE while in_valid toggles with new operands.
        run_op(16'h1234, 16'h0234, 1'b0, 3, rd, rbo, rsk);
        chk("stall_diff", 32'(rd), 32'h1000);
        chk("stall_skip", 32'(rsk), 32'd3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_capture", 32'(out_valid), 32'd0);
        end

        // Abort in RUN: reset after two RUN cycles, no result ever shows.
        @(negedge clk);
        a = 16'h8000; b = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_skip", 32'(skip_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_result", 32'(n), 32'd0);
        chk("abort_idle", 32'(in_ready), 32'd1);
        run_op(16'h8000, 16'h0001, 1'b0, 0, rd, rbo, rsk);
        chk("post_abort_diff", 32'(rd), 32'h7FFF);
        chk("post_abort_bout", 32'(rbo), 32'd0);
        chk("post_abort_skip", 32'(rsk), 32'd2);

        // Randomized operations against the reference model; nibbles often shared to hit bypass.
        for (int t = 0; t < 60; t++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom);
            for (int k = 0; k < int'(NBLK); k++)
                if ($urandom_range(0, 1) == 1)
                    for (int j = 0; j < 4; j++) rb[4 * k + j] = ra[4 * k + j];
            model(ra, rb, rbin, md, mbo, msk);
            run_op(ra, rb, rbin, $urandom_range(0, 2), rd, rbo, rsk);
            chk("rand_diff", 32'(rd), 32'(md));
            chk("rand_bout", 32'(rbo), 32'(mbo));
            chk("rand_skip", 32'(rsk), 32'(msk));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
